// File: rtl/debounce_pkg.sv
// ============================================================================
// Module  : debounce_pkg
// Brief   : State encoding and timing constants for the push-button debouncer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package debounce_pkg;

    // Codes are explicit so the debug bus can expose the state directly.
    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        WAIT_PRESS   = 2'd1,
        PRESSED      = 2'd2,
        WAIT_RELEASE = 2'd3
    } db_state_t;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;
    localparam int DEBOUNCE_CYCLES_SIM     = 4;

endpackage

`default_nettype wire

// File: rtl/sync2.sv
// ============================================================================
// Module  : sync2
// Brief   : Two-flop synchronizer for asynchronous button and switch inputs.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic s1_d, s1_q;
    logic s2_d, s2_q;

    always_comb begin
        s1_d = d;
        s2_d = s1_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign q = s2_q;

endmodule

`default_nettype wire

// File: rtl/button_debouncer.sv
// ============================================================================
// Module  : button_debouncer
// Brief   : Synchronizes and debounces a push-button into a clean press level
//           with registered press/release pulses and a debug state bus.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module button_debouncer
    import debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_WIDTH       = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_raw,
    output logic       press,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic [2:0] statePMOD
);

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    logic                 btn_sync;
    db_state_t            state_d, state_q;
    logic [CNT_WIDTH-1:0] cnt_d, cnt_q;
    logic                 press_d, press_q;
    logic                 press_pulse_d, press_pulse_q;
    logic                 release_pulse_d, release_pulse_q;
    logic                 cnt_done;

    sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn_raw),
        .q   (btn_sync)
    );

    assign cnt_done = (cnt_q == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            press_q         <= 1'b0;
            press_pulse_q   <= 1'b0;
            release_pulse_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            press_q         <= press_d;
            press_pulse_q   <= press_pulse_d;
            release_pulse_q <= release_pulse_d;
        end
    end

    // Counter stops at CNT_LAST, where the state leaves the wait state anyway.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        case (state_q)
            IDLE: begin
                if (btn_sync) state_d = WAIT_PRESS;
            end
            WAIT_PRESS: begin
                if (!btn_sync)     state_d = IDLE;
                else if (cnt_done) state_d = PRESSED;
                else               cnt_d   = cnt_q + CNT_ONE;
            end
            PRESSED: begin
                if (!btn_sync) state_d = WAIT_RELEASE;
            end
            WAIT_RELEASE: begin
                if (btn_sync)      state_d = PRESSED;
                else if (cnt_done) state_d = IDLE;
                else               cnt_d   = cnt_q + CNT_ONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        press_d         = press_q;
        press_pulse_d   = 1'b0;
        release_pulse_d = 1'b0;
        case (state_q)
            IDLE:    press_d = 1'b0;
            PRESSED: press_d = 1'b1;
            WAIT_PRESS: begin
                if (btn_sync && cnt_done) begin
                    press_d       = 1'b1;
                    press_pulse_d = 1'b1;
                end
            end
            WAIT_RELEASE: begin
                if (!btn_sync && cnt_done) begin
                    press_d         = 1'b0;
                    release_pulse_d = 1'b1;
                end
            end
            default: press_d = 1'b0;
        endcase
    end

    assign press         = press_q;
    assign press_pulse   = press_pulse_q;
    assign release_pulse = release_pulse_q;
    assign statePMOD     = {btn_sync, state_q};

endmodule

`default_nettype wire

// File: doc/button_debouncer.md
# button_debouncer

Conditions the raw push-button into the clean `press` level consumed by the interrupt FSM, which raises the MCU interrupt and re-arms only after `press` falls. Two-flop synchronizer, then a four-state debounce FSM with a stable-cycle counter. A level change is accepted only after the synchronized input holds the new value for `DEBOUNCE_CYCLES` consecutive clocks. Registered one-cycle edge pulses and a debug state bus for the PMOD header are also produced.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles required to accept a level change (5 ms at 100 MHz). Legal values are 2 or more.
- `CNT_WIDTH`, default `$clog2(DEBOUNCE_CYCLES)`: counter width. Derived; never overridden.
- `clk`, in, 1: system clock. Single clock domain.
- `rst`, in, 1: reset, synchronous, active-high.
- `btn_raw`, in, 1: asynchronous, bouncing button input.
- `press`, out, 1: debounced level. Feeds the interrupt FSM `press` input.
- `press_pulse`, out, 1: one-cycle pulse when a press is accepted.
- `release_pulse`, out, 1: one-cycle pulse when a release is accepted.
- `statePMOD`, out, 3: debug bus. Bits [1:0] carry the state code; bit [2] carries the synchronized input.

## Operation
- Synchronizer: `s1 <= btn_raw`, `s2 <= s1`. The FSM sees `s2` only.
- States and codes: IDLE=0, WAIT_PRESS=1, PRESSED=2, WAIT_RELEASE=3.
- IDLE:
  - `s2`=1: go to WAIT_PRESS, counter cleared to 0.
  - Otherwise stay in IDLE.
- WAIT_PRESS:
  - `s2`=0: go to IDLE, counter cleared to 0. No output changes (glitch rejected).
  - `s2`=1 and counter = `DEBOUNCE_CYCLES`-1: go to PRESSED. Set `press`=1 and `press_pulse`=1 for one cycle.
  - Otherwise increment the counter.
- PRESSED: mirror image of IDLE. `s2`=0 goes to WAIT_RELEASE with the counter cleared.
- WAIT_RELEASE: mirror image of WAIT_PRESS.
  - `s2`=1: return to PRESSED, counter cleared.
  - `s2`=0 and counter at terminal value: go to IDLE. Set `press`=0 and `release_pulse`=1 for one cycle.
- Counter:
  - Width `CNT_WIDTH`, unsigned.
  - Compared against `DEBOUNCE_CYCLES`-1 and never incremented past it, so it cannot wrap.
  - Held at 0 in IDLE and PRESSED.
- Illegal or unreachable state encodings go to IDLE on the next edge with all outputs at 0.
- `press_pulse` and `release_pulse` are never high in the same cycle. Each pulse is high only in the first cycle of its destination state.

## Timing
- All outputs are registered. Nothing combinational runs from `btn_raw` to any output.
- Reset, with `rst` high at an edge, forces:
  - `s1`=`s2`=0 and state IDLE.
  - Counter 0.
  - `press`=0, `press_pulse`=0, `release_pulse`=0.
  - `statePMOD`=3'b000.
- Press latency: take edge 0 as the first edge sampling `btn_raw`=1, with the input stable from then on. `press` and `press_pulse` are high after edge `DEBOUNCE_CYCLES`+2. `press_pulse` falls after the following edge.
- Release latency is symmetric: `press` falls after edge `DEBOUNCE_CYCLES`+2, counted from the first edge sampling 0.
- A bounce of any length under `DEBOUNCE_CYCLES` synchronized cycles produces no output activity. The counter restarts from 0 on every reversal.
- Reset mid-WAIT_PRESS: the count is aborted and no pulse is emitted.
- Reset while PRESSED: `press` drops with no `release_pulse`.
- Button held through reset deassertion: treated as a fresh press. `press` rises `DEBOUNCE_CYCLES`+2 edges after the first non-reset edge.
- Downstream contract: `press` stays high for the whole hold, so the interrupt FSM RELOAD state blocks re-triggering until the accepted release.

## Structure
- Package `debounce_pkg`:
  - `typedef enum logic [1:0] {IDLE, WAIT_PRESS, PRESSED, WAIT_RELEASE} db_state_t`, with explicit codes 0-3 so that `statePMOD[1:0]` equals the state.
  - Default `DEBOUNCE_CYCLES` constant.
  - Simulation constant `DEBOUNCE_CYCLES_SIM` = 4.
- Sub-module `sync2`: a two-flop synchronizer with ports `clk`, `rst`, `d`, `q`. It is reused for the switch inputs.
- The FSM, counter and output registers stay in `button_debouncer`.

## Test plan
Run with `DEBOUNCE_CYCLES`=4.
- Reset: hold `rst` for 3 cycles with `btn_raw`=1 → all outputs 0 during reset. After release, `press`=1 exactly 6 edges after the first non-reset edge.
- Clean press: `btn_raw` 0→1 sampled at edge 0 → `press`=1 and `press_pulse`=1 after edge 6, `press_pulse`=0 after edge 7, `statePMOD`=3'b110.
- Bounce on press: `btn_raw` pattern 1,1,0,1,1,1,1 and then held → one `press_pulse` only, 6 edges after the last rising sample. `statePMOD[1:0]` shows WAIT_PRESS→IDLE→WAIT_PRESS.
- Glitch rejection: a 3-cycle high pulse on `btn_raw` from IDLE → `press`, `press_pulse` and `release_pulse` stay 0 throughout.
- Release with bounce while PRESSED: `btn_raw` 0,1,0,0,0,0 → a single `release_pulse` with `press`=0 6 edges after the last falling sample. No `press_pulse`.
- Reset mid-WAIT_PRESS, after 2 counted cycles → no pulse, state IDLE, and the debounce restarts from 0 after reset.
